// File: rtl/score_digits_pkg.sv
// Shared constants, FSM encoding and BCD helper for the score display.
package score_digits_pkg;

  localparam int unsigned NumDigits = 6;
  localparam int unsigned GlyphW    = 16;
  localparam int unsigned GlyphH    = 20;
  localparam int unsigned NumIters  = 20;
  localparam int unsigned BcdW      = 4 * NumDigits;

  localparam logic [19:0] ScoreMax = 20'd999999;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } conv_state_e;

  // Double-dabble pre-shift correction: add 3 to every nibble >= 5.
  function automatic logic [BcdW-1:0] bcd_adjust(input logic [BcdW-1:0] bcd);
    logic [BcdW-1:0] r;
    r = bcd;
    for (int i = 0; i < NumDigits; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_digits_bin2bcd_seq.sv
// Sequential double-dabble converter; bcd only changes while leaving DONE.
module bin2bcd_seq
  import score_digits_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [19:0] bin,
  output logic        busy,
  output logic        done,
  output logic [23:0] bcd
);

  conv_state_e state_q, state_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] acc_q, acc_d;
  logic [23:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = (bin > ScoreMax) ? ScoreMax : bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        {acc_d, bin_d} = {bcd_adjust(acc_q), bin_q} << 1;
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'(NumIters - 1)) state_d = StDone;
      end
      StDone: begin
        bcd_d   = acc_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      bin_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_digits.sv
// Six-digit score display: BCD conversion plus per-slot pixel geometry for a VGA raster.
module score_digits
  import score_digits_pkg::*;
#(
  parameter logic [9:0] X0  = 10'd560,
  parameter logic [9:0] Y0  = 10'd8,
  parameter logic [9:0] GAP = 10'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [19:0] score,
  input  logic        load,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  output logic        busy,
  output logic [23:0] number_type,
  output logic [59:0] number_hc,
  output logic [59:0] number_vc,
  output logic [5:0]  is_number_in_pixel
);

  logic [23:0] bcd;
  logic        conv_done;

  bin2bcd_seq u_bin2bcd (
    .CLK   (CLK),
    .RST   (RST),
    .start (load),
    .bin   (score),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Converter keeps the most significant digit in the top nibble; slot 0 wants it at [3:0].
  always_comb begin
    number_type = '0;
    for (int i = 0; i < NumDigits; i++) begin
      number_type[4*i +: 4] = bcd[4*(NumDigits-1-i) +: 4];
    end
  end

  logic [5:0]  in_q, in_d;
  logic [59:0] nhc_q, nhc_d;
  logic [59:0] nvc_q, nvc_d;
  logic [10:0] x_lo;
  logic        row_hit;

  // Compare in 11 bits so a slot near the right edge cannot wrap its upper bound.
  always_comb begin
    in_d    = '0;
    nhc_d   = '0;
    nvc_d   = '0;
    x_lo    = '0;
    row_hit = ({1'b0, vc} >= {1'b0, Y0}) && ({1'b0, vc} < {1'b0, Y0} + 11'(GlyphH));
    for (int i = 0; i < NumDigits; i++) begin
      x_lo  = {1'b0, X0} + 11'(i) * (11'(GlyphW) + {1'b0, GAP});
      in_d[i] = row_hit && ({1'b0, hc} >= x_lo) && ({1'b0, hc} < x_lo + 11'(GlyphW));
      nhc_d[10*i +: 10] = hc - x_lo[9:0];
      nvc_d[10*i +: 10] = vc - Y0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_q  <= '0;
      nhc_q <= '0;
      nvc_q <= '0;
    end else begin
      in_q  <= in_d;
      nhc_q <= nhc_d;
      nvc_q <= nvc_d;
    end
  end

  assign is_number_in_pixel = in_q;
  assign number_hc          = nhc_q;
  assign number_vc          = nvc_q;

endmodule

// File: doc/score_digits.md
SCORE_DIGITS -- requirements
Module: score_digits

Interface
REQ-001 SHALL have parameter X0, default 10'd560, meaning the left column of slot 0.
REQ-002 SHALL have parameter Y0, default 10'd8, meaning the top row of all slots.
REQ-003 SHALL have parameter GAP, default 10'd4, meaning the blank columns between adjacent slots.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port score, input, 20 bits: binary score to display.
REQ-007 SHALL have port load, input, 1 bit: one-cycle request to convert score.
REQ-008 SHALL have ports hc and vc, input, 10 bits each: current VGA pixel column and row.
REQ-009 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-010 SHALL have port number_type, output, 24 bits: six 4-bit BCD digits; bits [3:0] are slot 0, the most significant digit.
REQ-011 SHALL have ports number_hc and number_vc, output, 60 bits each: six 10-bit pixel offsets inside each slot; bits [9:0] are slot 0.
REQ-012 SHALL have port is_number_in_pixel, output, 6 bits: bit i high when the current pixel lies in slot i.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 SHALL, when load is high in IDLE, capture min(score, 999999), clear the 24-bit BCD accumulator and iteration counter, and enter SHIFT.
REQ-015 SHALL ignore load outside IDLE; a load arriving during SHIFT or DONE has no effect.
REQ-016 SHALL perform one double-dabble step per SHIFT cycle: add 3 to every BCD nibble >= 5, then shift the concatenation {bcd, bin} left by one bit.
REQ-017 SHALL leave SHIFT after exactly 20 steps and enter DONE.
REQ-018 SHALL, in DONE, copy the accumulator into number_type in a single cycle, so that all six digits change atomically, and then return to IDLE.
REQ-019 SHALL hold busy high in SHIFT and DONE and low in IDLE.
REQ-020 SHALL update number_type 22 cycles after the load edge; busy SHALL be high for 21 cycles.
REQ-021 SHALL keep number_type unchanged outside DONE, so that the displayed digits stay stable during conversion.
REQ-022 SHALL define slot i as starting at column xi = X0 + i*(16+GAP), with a box 16 columns wide and 20 rows tall starting at row Y0; this is the 4x5 glyph scaled by 4.
REQ-023 SHALL register is_number_in_pixel[i] as (hc >= xi && hc < xi+16 && vc >= Y0 && vc < Y0+20); latency is 1 cycle from hc/vc.
REQ-024 SHALL register number_hc slot i as (hc - xi) mod 1024 and number_vc slot i as (vc - Y0) mod 1024, with the same 1-cycle latency; values are 0..15 and 0..19 when inside the slot.
REQ-025 SHALL compute the geometry path independently of the FSM, so that it is never stalled by a conversion.

Reset
REQ-026 SHALL, with RST high at a clock edge, force the FSM to IDLE, busy to 0, number_type to 0 (display "000000"), is_number_in_pixel to 0, number_hc and number_vc to 0, and the accumulator and counter to 0.
REQ-027 SHALL abort a conversion in progress on reset, with no partial digits reaching number_type.
REQ-028 SHALL give RST priority over load when both are high on the same edge.

Structure
REQ-029 SHALL place the digit count (6), glyph box size (16x20), iteration count (20) and the FSM state encoding in the shared game package.
REQ-030 SHALL implement the conversion in one sub-module, bin2bcd_seq, with ports CLK, RST, start, bin[19:0], busy, done and bcd[23:0]; score_digits instantiates it and owns the geometry logic.

Verification
REQ-031 SHALL cover: load with score=12345 -> after 22 cycles number_type reads digits 0,1,2,3,4,5 for slots 0..5, and busy is high for 21 cycles.
REQ-032 SHALL cover: load with score=1048575 -> clamped; digits read 9,9,9,9,9,9.
REQ-033 SHALL cover: a second load 5 cycles after the first -> ignored; the result equals the first score, and the FSM returns to IDLE once.
REQ-034 SHALL cover: RST asserted at step 10 of a conversion -> busy=0 next cycle, number_type stays 0, and a following load converts correctly.
REQ-035 SHALL cover: defaults with hc=580 and vc=10 -> next cycle is_number_in_pixel=6'b000010, slot 1 offset hc 0 and vc 2; hc=596 -> no bit set (this column is the gap).
REQ-036 SHALL cover: hc and vc sweeping a full frame during a conversion -> the geometry outputs are identical to a sweep with no conversion running.
